fdsti_info_reader: RTL
======================

# fdsti_info_reader

Read-side counterpart of the FDSSI-to-FDSTI info FIFO stage. It drains the per-target info FIFOs (one AXI-Stream-style lane per FDSTI index) with round-robin arbitration. Each popped entry {FDSSI, SSI, STI, block count} is expanded into one output beat per block, tagged with the FDSTI lane it came from. It sits between the target FIFO bank and the downstream per-block address/request generator, and reports completion once input is finished and every lane is drained.

## Interface
- O_TAM_WIDTH, 2, log2 of target lane count; T = 2**O_TAM_WIDTH lanes
- I_FDSSI_WIDTH, 12, source index field width
- I_SSI_WIDTH, 8, SSI field width
- I_STI_WIDTH, 8, STI field width
- LWIDTH, 32, block count field width
- T_INFO_DATA_WIDTH, I_FDSSI_WIDTH+I_SSI_WIDTH+I_STI_WIDTH+LWIDTH, entry width; packing MSB→LSB: fdssi, ssi, sti, len

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_info_valid  in  T  per-lane entry valid (FIFO m_axis_tvalid)
- s_info_ready  out  T  per-lane pop (FIFO m_axis_tready)
- s_info  in  T*T_INFO_DATA_WIDTH  lane j at [j*T_INFO_DATA_WIDTH +: T_INFO_DATA_WIDTH]
- in_finish  in  1  pulse or level: upstream has written all entries
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_fdsti  out  O_TAM_WIDTH  lane index of current entry
- m_fdssi  out  I_FDSSI_WIDTH  latched fdssi
- m_ssi  out  I_SSI_WIDTH  latched ssi
- m_sti  out  I_STI_WIDTH  latched sti
- m_blk  out  LWIDTH  block index within entry, 0..len-1
- m_last  out  1  high on beat with m_blk == len-1
- done  out  1  all input finished and drained

## Operation
- Two-state FSM: IDLE, EMIT.
- IDLE: round-robin grant among asserted s_info_valid. Search starts at rr_ptr and wraps modulo T. s_info_ready[g] = 1 combinationally for the granted lane only; all other bits are 0.
- On a grant handshake, latch fdssi/ssi/sti/len and lane g into m_fdsti, clear m_blk, and set rr_ptr = g+1 mod T.
  - len != 0: go to EMIT.
  - len == 0: entry is consumed with no beats; stay IDLE.
- EMIT: m_valid = 1. When m_valid && m_ready:
  - m_blk == len-1: go to IDLE.
  - otherwise: m_blk increments.
- m_last = (state == EMIT) && (m_blk == len-1), combinational from registered state.
- s_info_ready is all zero in EMIT. Exactly one entry is in flight.
- in_finish is latched into sticky in_finish_r, which is cleared only by rst.
- done: registered, high when in_finish_r && state == IDLE && s_info_valid == 0. It re-evaluates every cycle, so it drops if a lane becomes valid again.
- Arithmetic is unsigned. m_blk is LWIDTH wide; len up to 2**LWIDTH-1 is supported without wrap.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, in_finish_r 0, done 0.
  - m_valid 0, m_last 0, s_info_ready 0.
  - m_fdsti, m_fdssi, m_ssi, m_sti, m_blk all 0.
- Latency: entry accepted at edge N → first beat valid after edge N (visible cycle N+1).
- Throughput: one beat per cycle within an entry. There is one IDLE cycle between entries, so an entry of len L occupies L+1 cycles with m_ready held high.
- Backpressure: while m_valid && !m_ready, all m_* outputs stay stable.
- Simultaneous in_finish and lane valid: the entry is served first. done rises only after the final beat's handshake plus one cycle in IDLE with no valids.
- rst mid-EMIT: the in-flight entry is discarded, and all outputs return to reset values asynchronously.
- An entry's fields do not change during EMIT even if the FIFO heads change.

## Test plan
- Reset: assert rst mid-EMIT (len=5, beat 2) → m_valid, m_last, s_info_ready, done = 0 immediately. After release, no beats are emitted until a new valid arrives.
- Lane 2 holds {fdssi=7, ssi=3, sti=9, len=3}, m_ready=1:
  - s_info_ready=4'b0100 for one cycle.
  - The next 3 cycles show m_fdsti=2, m_fdssi=7, m_blk=0,1,2; m_last only on blk 2.
- Lane 0 holds len=0, then len=1 → the len=0 entry is popped with no beats. The next entry yields a single beat with m_blk=0, m_last=1.
- Lanes 0 and 3 both continuously valid, len=1 each → grants alternate 0,3,0,3. rr_ptr wraps 0→1, then 3→0.
- Backpressure: len=4, m_ready toggled 1,0,0,1,1,0,1 → outputs hold during stalls. Exactly 4 accepted beats (blk 0..3) and no extra pop.
- Completion: pulse in_finish while lane 1 holds len=2 → done stays 0 through both beats, rises 2 cycles after the last handshake, then drops the cycle after lane 1 valid reasserts.

Source files
------------

// File: rtl/fdsti_info_reader.sv
// fdsti_info_reader: drains per-lane target info FIFOs round-robin and expands
// each {fdssi, ssi, sti, len} entry into len output beats tagged with its lane.
// Latency: first beat one cycle after the pop; backpressure: m_ready stall holds all m_* stable.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   s_info_valid/_ready/s_info   per-lane FIFO heads (lane j at [j*W +: W])
//   in_finish         upstream has written every entry (pulse or level)
//   m_valid/m_ready   output beat handshake
//   m_fdsti, m_fdssi, m_ssi, m_sti, m_blk, m_last   beat payload
//   done              input finished and every lane drained
module fdsti_info_reader #(
    parameter int O_TAM_WIDTH       = 2,
    parameter int I_FDSSI_WIDTH     = 12,
    parameter int I_SSI_WIDTH       = 8,
    parameter int I_STI_WIDTH       = 8,
    parameter int LWIDTH            = 32,
    parameter int T_INFO_DATA_WIDTH = I_FDSSI_WIDTH + I_SSI_WIDTH + I_STI_WIDTH + LWIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [(2**O_TAM_WIDTH)-1:0]      s_info_valid,
    output logic [(2**O_TAM_WIDTH)-1:0]      s_info_ready,
    input  logic [(2**O_TAM_WIDTH)*T_INFO_DATA_WIDTH-1:0] s_info,
    input  logic                             in_finish,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [O_TAM_WIDTH-1:0]           m_fdsti,
    output logic [I_FDSSI_WIDTH-1:0]         m_fdssi,
    output logic [I_SSI_WIDTH-1:0]           m_ssi,
    output logic [I_STI_WIDTH-1:0]           m_sti,
    output logic [LWIDTH-1:0]                m_blk,
    output logic                             m_last,
    output logic                             done
);

    localparam int T = 2 ** O_TAM_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [O_TAM_WIDTH-1:0]     r_rr_ptr;
    logic [O_TAM_WIDTH-1:0]     r_fdsti;
    logic [I_FDSSI_WIDTH-1:0]   r_fdssi;
    logic [I_SSI_WIDTH-1:0]     r_ssi;
    logic [I_STI_WIDTH-1:0]     r_sti;
    logic [LWIDTH-1:0]          r_len;
    logic [LWIDTH-1:0]          r_blk;
    logic                       r_fin;
    logic                       r_done;

    logic                       w_gnt_vld;
    logic [O_TAM_WIDTH-1:0]     w_gnt;
    logic [O_TAM_WIDTH-1:0]     w_idx;
    logic [T_INFO_DATA_WIDTH-1:0] w_ent;
    logic [LWIDTH-1:0]          w_len;
    logic [I_STI_WIDTH-1:0]     w_sti;
    logic [I_SSI_WIDTH-1:0]     w_ssi;
    logic [I_FDSSI_WIDTH-1:0]   w_fdssi;
    logic                       w_take;
    logic                       w_beat;
    logic                       w_at_last;

    // Round-robin search: walk offsets from T-1 down to 0 so the lane closest
    // to r_rr_ptr (smallest offset) is the last, and therefore winning, write.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_idx     = '0;
        for (int i = T - 1; i >= 0; i--) begin
            w_idx = r_rr_ptr + O_TAM_WIDTH'(i);
            if (s_info_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_idx;
            end
        end
    end

    assign w_ent   = s_info[w_gnt*T_INFO_DATA_WIDTH +: T_INFO_DATA_WIDTH];
    assign w_len   = w_ent[LWIDTH-1:0];
    assign w_sti   = w_ent[LWIDTH +: I_STI_WIDTH];
    assign w_ssi   = w_ent[LWIDTH+I_STI_WIDTH +: I_SSI_WIDTH];
    assign w_fdssi = w_ent[LWIDTH+I_STI_WIDTH+I_SSI_WIDTH +: I_FDSSI_WIDTH];

    // Ready is only offered to a lane that is valid, so ready==handshake.
    assign w_take    = (r_state == S_IDLE) && w_gnt_vld;
    assign w_beat    = (r_state == S_EMIT) && m_ready;
    assign w_at_last = (r_blk == (r_len - LWIDTH'(1)));

    // Gated by rst so no pop is offered while the block is held in reset.
    always_comb begin
        s_info_ready = '0;
        if (!rst && w_take) begin
            s_info_ready[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // A zero-length entry is popped and dropped without beats.
                if (w_take && (w_len != '0)) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_beat && w_at_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_fdsti  <= '0;
            r_fdssi  <= '0;
            r_ssi    <= '0;
            r_sti    <= '0;
            r_len    <= '0;
            r_blk    <= '0;
            r_fin    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_fin  <= r_fin | in_finish;
            r_done <= r_fin && (r_state == S_IDLE) && (s_info_valid == '0);
            if (w_take) begin
                r_fdsti  <= w_gnt;
                r_fdssi  <= w_fdssi;
                r_ssi    <= w_ssi;
                r_sti    <= w_sti;
                r_len    <= w_len;
                r_blk    <= '0;
                r_rr_ptr <= w_gnt + O_TAM_WIDTH'(1);
            end else if (w_beat && !w_at_last) begin
                r_blk <= r_blk + LWIDTH'(1);
            end
        end
    end

    assign m_valid = (r_state == S_EMIT);
    assign m_last  = (r_state == S_EMIT) && w_at_last;
    assign m_fdsti = r_fdsti;
    assign m_fdssi = r_fdssi;
    assign m_ssi   = r_ssi;
    assign m_sti   = r_sti;
    assign m_blk   = r_blk;
    assign done    = r_done;

endmodule
